// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 raster constants and scan-control types for the
// read-side scan controller and the write-side pipeline.
package vga_pkg;

  localparam int CNT_W      = 10;
  localparam int RD_LATENCY = 2;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Syncs are active-low, so the idle word keeps them high.
  typedef struct packed {
    logic frame;
    logic vs;
    logic hs;
    logic active;
  } scan_ctl_t;

  localparam scan_ctl_t SCAN_CTL_IDLE = '{frame: 1'b0, vs: 1'b1, hs: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift register that realigns raster control bits with the
// frame-buffer read data. Each stage resets to RST_VAL.
module vga_delay_line #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= RST_VAL;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// Read-side VGA scan controller: raster counters, frame-buffer address gating and
// latency-matched DAC output register. Optional colour-bar mode: VGA_TEST_PATTERN_EN.
module vga_scan_ctrl #(
  parameter int DATA_W     = 8,
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int RD_LATENCY = vga_pkg::RD_LATENCY
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [vga_pkg::CNT_W-1:0] pixel_x,
  output logic [vga_pkg::CNT_W-1:0] pixel_y,
  input  logic [DATA_W-1:0]         pixel_val,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                      pattern_sel,
`endif
  output logic [DATA_W-1:0]         vga_r,
  output logic [DATA_W-1:0]         vga_g,
  output logic [DATA_W-1:0]         vga_b,
  output logic                      vga_hs,
  output logic                      vga_vs,
  output logic                      vga_blank_n,
  output logic                      vga_sync_n,
  output logic                      frame_start
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [3*DATA_W-1:0] bar_colour(input logic [2:0] bar);
    logic [2:0] rgb;
    rgb = ~bar;
    return {{DATA_W{rgb[2]}}, {DATA_W{rgb[1]}}, {DATA_W{rgb[0]}}};
  endfunction

  logic [CNT_W-1:0] h_cnt, v_cnt;
  scan_ctl_t        ctl_p0, ctl_p1;
  logic [DATA_W-1:0] pix_nx;
  logic [3*DATA_W-1:0] col_nx;

  // Stage p0: raster counters; h and v wrap together at the last pixel of the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    ctl_p0        = SCAN_CTL_IDLE;
    ctl_p0.active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    ctl_p0.hs     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    ctl_p0.vs     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    ctl_p0.frame  = (h_cnt == '0) && (v_cnt == '0);
  end

  // Gating the address outside the visible area keeps y*H_ACTIVE+x inside the RAM.
  assign pixel_x = ctl_p0.active ? h_cnt : '0;
  assign pixel_y = ctl_p0.active ? v_cnt : '0;

  // Stage p1: control realigned with pixel_val after the RAM read latency.
`ifdef VGA_TEST_PATTERN_EN
  localparam int              DL_W   = $bits(scan_ctl_t) + 3;
  localparam logic [DL_W-1:0] DL_RST = {3'b000, SCAN_CTL_IDLE};
  logic [2:0]      bar_p1;
  logic [DL_W-1:0] dl_din, dl_dout;
  assign dl_din           = {h_cnt[9:7], ctl_p0};
  assign {bar_p1, ctl_p1} = dl_dout;
`else
  localparam int              DL_W   = $bits(scan_ctl_t);
  localparam logic [DL_W-1:0] DL_RST = SCAN_CTL_IDLE;
  logic [DL_W-1:0] dl_din, dl_dout;
  assign dl_din = ctl_p0;
  assign ctl_p1 = dl_dout;
`endif

  vga_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (RD_LATENCY),
    .RST_VAL (DL_RST)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (dl_din),
    .dout  (dl_dout)
  );

  always_comb begin
    pix_nx = ctl_p1.active ? pixel_val : '0;
    col_nx = {pix_nx, pix_nx, pix_nx};
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel && ctl_p1.active) col_nx = bar_colour(bar_p1);
`endif
  end

  // Stage p2: registered DAC outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= col_nx;
      vga_hs                <= ctl_p1.hs;
      vga_vs                <= ctl_p1.vs;
      vga_blank_n           <= ctl_p1.active;
      frame_start           <= ctl_p1.frame;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: a full-size 640x480 instance and a shrunken
// raster instance, both checked against an arithmetic raster model.
module tb_vga_scan_ctrl;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       fs;
    logic [9:0] px;
    logic [9:0] py;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } tim_t;

  localparam obs_t IDLE = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1,
                            blank_n: 1'b0, fs: 1'b0, px: 10'd0, py: 10'd0};

  tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33};
  tim_t TB = '{40, 4, 8, 6, 20, 2, 2, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pat = 1'b0;
  logic [7:0] seed_a, seed_b;

  logic [9:0] px_a, py_a, px_b, py_b;
  logic [7:0] pv_a, pv_b, rd1_a, rd1_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic hs_a, vs_a, bn_a, sn_a, fs_a, hs_b, vs_b, bn_b, sn_b, fs_b;

  obs_t qa[$];
  obs_t qb[$];
  int   idx;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vga_scan_ctrl dut_a (
    .clk(clk), .reset(reset), .pixel_x(px_a), .pixel_y(py_a), .pixel_val(pv_a),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pat),
`endif
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_blank_n(bn_a), .vga_sync_n(sn_a), .frame_start(fs_a)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (
    .clk(clk), .reset(reset), .pixel_x(px_b), .pixel_y(py_b), .pixel_val(pv_b),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pat),
`endif
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_blank_n(bn_b), .vga_sync_n(sn_b), .frame_start(fs_b)
  );

  function automatic logic [7:0] ram_val(input int x, input int y, input logic [7:0] s);
    return 8'(x + 37 * y + int'(s));
  endfunction

  // Frame buffer with a two-clock read latency.
  always @(posedge clk) begin
    rd1_a <= ram_val(int'(px_a), int'(py_a), seed_a);
    pv_a  <= rd1_a;
    rd1_b <= ram_val(int'(px_b), int'(py_b), seed_b);
    pv_b  <= rd1_b;
  end

  // Expected appearance of pixel number n (counted from reset release) of a raster.
  function automatic obs_t model(input tim_t t, input int n, input logic [7:0] s, input logic p);
    obs_t o;
    int ht, vt, h, v, bar;
    bit act;
    logic [7:0] val;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    h = n % ht;
    v = (n / ht) % vt;
    act = (h < t.ha) && (v < t.va);
    o.hs = !((h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs));
    o.vs = !((v >= t.va + t.vf) && (v < t.va + t.vf + t.vs));
    o.blank_n = act;
    o.fs = (h == 0) && (v == 0);
    o.px = act ? 10'(h) : 10'd0;
    o.py = act ? 10'(v) : 10'd0;
    val = act ? ram_val(h, v, s) : 8'h00;
    o.r = val;
    o.g = val;
    o.b = val;
    if (p && act) begin
      bar = (h / 128) % 8;
      o.r = (bar & 4) != 0 ? 8'h00 : 8'hFF;
      o.g = (bar & 2) != 0 ? 8'h00 : 8'hFF;
      o.b = (bar & 1) != 0 ? 8'h00 : 8'hFF;
    end
    return o;
  endfunction

  function automatic logic [28:0] pk(input obs_t o);
    return {o.r, o.g, o.b, o.hs, o.vs, o.blank_n, o.fs, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic release_rst();
    reset = 1'b0;
    qa.delete();
    qb.delete();
    repeat (3) begin
      qa.push_back(IDLE);
      qb.push_back(IDLE);
    end
    qa.push_back(model(TA, 0, seed_a, pat));
    qb.push_back(model(TB, 0, seed_b, pat));
    idx = 1;
  endtask

  // Predictor: after each edge, the counters present the next pixel of the raster.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      qa.push_back(model(TA, idx, seed_a, pat));
      qb.push_back(model(TB, idx, seed_b, pat));
      idx++;
    end
  end

  // Monitors: outputs show the entry three pixels back; addresses show the newest.
  always @(negedge clk) begin
    obs_t e;
    if (reset) begin
      check("a_reset_out", {3'b0, r_a, g_a, b_a, hs_a, vs_a, bn_a, fs_a, sn_a}, {3'b0, pk(IDLE)});
      check("a_reset_addr", {12'b0, px_a, py_a}, 32'd0);
    end else if (qa.size() == 0) begin
      check("a_queue_empty", 32'd1, 32'd0);
    end else begin
      e = qa[$];
      check("a_addr", {12'b0, px_a, py_a}, {12'b0, e.px, e.py});
      e = qa.pop_front();
      check("a_out", {3'b0, r_a, g_a, b_a, hs_a, vs_a, bn_a, fs_a, sn_a}, {3'b0, pk(e)});
    end
  end

  always @(negedge clk) begin
    obs_t e;
    if (reset) begin
      check("b_reset_out", {3'b0, r_b, g_b, b_b, hs_b, vs_b, bn_b, fs_b, sn_b}, {3'b0, pk(IDLE)});
      check("b_reset_addr", {12'b0, px_b, py_b}, 32'd0);
    end else if (qb.size() == 0) begin
      check("b_queue_empty", 32'd1, 32'd0);
    end else begin
      e = qb[$];
      check("b_addr", {12'b0, px_b, py_b}, {12'b0, e.px, e.py});
      e = qb.pop_front();
      check("b_out", {3'b0, r_b, g_b, b_b, hs_b, vs_b, bn_b, fs_b, sn_b}, {3'b0, pk(e)});
    end
  end

  initial begin
    seed_a = 8'($urandom);
    seed_b = 8'($urandom);
`ifdef VGA_TEST_PATTERN_EN
    pat = 1'($urandom);
`endif
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #3 release_rst();
    repeat (6000) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      #2 reset = 1'b1;
      #1;
      check("a_async_reset", {3'b0, r_a, g_a, b_a, hs_a, vs_a, bn_a, fs_a, sn_a}, {3'b0, pk(IDLE)});
      check("b_async_reset", {3'b0, r_b, g_b, b_b, hs_b, vs_b, bn_b, fs_b, sn_b}, {3'b0, pk(IDLE)});
      qa.delete();
      qb.delete();
      repeat (2 + $urandom_range(0, 3)) @(posedge clk);
      #3 release_rst();
      repeat (1500 + $urandom_range(0, 1500)) @(posedge clk);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule
